alu_mdu: RTL and testbench

Parametrised, handshaked successor of the single-cycle integer ALU. Computes base RV integer ops (1-cycle registered) and RV M-extension multiply/divide (iterative, multi-cycle) on XLEN-bit operands. Sits in the execute stage between operand select and writeback, using valid/ready handshakes on both sides so the pipeline can stall on long ops.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_mdu_iter.sv | 97 +++++++++
 rtl/alu_mdu.sv | 188 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by alu_mdu and its iterative engine.
// Latency and backpressure: n/a (types and helpers only).
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD      = 5'd0,
        OP_SUB      = 5'd1,
        OP_AND      = 5'd2,
        OP_OR       = 5'd3,
        OP_XOR      = 5'd4,
        OP_SLL      = 5'd5,
        OP_SRL      = 5'd6,
        OP_SRA      = 5'd7,
        OP_SLT      = 5'd8,
        OP_SLTU     = 5'd9,
        OP_LUI      = 5'd10,
        OP_AUIPC    = 5'd11,
        OP_OUT_ZERO = 5'd12,
        OP_OUT_ONE  = 5'd13,
        OP_MUL      = 5'd16,
        OP_MULH     = 5'd17,
        OP_MULHSU   = 5'd18,
        OP_MULHU    = 5'd19,
        OP_DIV      = 5'd20,
        OP_DIVU     = 5'd21,
        OP_REM      = 5'd22,
        OP_REMU     = 5'd23
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int IMM_SHIFT = 12;

    function automatic logic is_muldiv(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes (divider only with ALU_MDU_DIV_EN).
// Latency XLEN cycles after i_start; o_done marks the final step; no backpressure, the owner samples o_hi/o_lo afterwards.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_start,
`ifdef ALU_MDU_DIV_EN
    input  logic            i_is_div,
`endif
    input  logic [XLEN-1:0] i_mag_a,
    input  logic [XLEN-1:0] i_mag_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int CNT_W = $clog2(XLEN);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic [XLEN:0]    w_mul_sum;
    logic [XLEN-1:0]  w_hi_nxt;
    logic [XLEN-1:0]  w_lo_nxt;

`ifdef ALU_MDU_DIV_EN
    logic             r_is_div;
    logic [XLEN:0]    w_div_shift;
    logic [XLEN:0]    w_div_diff;

    // Remainder in r_hi, dividend shifts out of r_lo while quotient bits shift in.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
`endif

    // Multiplier in r_lo, partial product accumulates in r_hi and shifts right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});

    always_comb begin
        w_hi_nxt = w_mul_sum[XLEN:1];
        w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
        if (r_is_div) begin
            if (!w_div_diff[XLEN]) begin
                w_hi_nxt = w_div_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    assign o_done = r_active && (r_cnt == CNT_W'(XLEN-1));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
`ifdef ALU_MDU_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (i_flush) begin
            r_active <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= i_mag_a;
            r_b      <= i_mag_b;
`ifdef ALU_MDU_DIV_EN
            r_is_div <= i_is_div;
`endif
        end else if (r_active) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU plus iterative MUL/DIV; divide datapath only when ALU_MDU_DIV_EN is defined.
// Latency: base ops and divide special cases 1 cycle, MUL*/DIV*/REM* XLEN+2 cycles after accept.
// Backpressure: result held in DONE until out_ready_i; in_ready_o low while iterating or stalled.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  alu_op_t         alu_op_i,
    input  logic [XLEN-1:0] alu_a_i,
    input  logic [XLEN-1:0] alu_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            busy_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    alu_op_t             r_op;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [XLEN-1:0]     r_result;
    logic                w_ready;
    logic                w_accept;
    logic                w_go_mul;
    logic                w_go_div;
    logic                w_start;
    logic                w_iter_done;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [XLEN-1:0]     w_base;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN-1:0]     w_iter_hi;
    logic [XLEN-1:0]     w_iter_lo;
    logic [XLEN-1:0]     w_fix;
    logic [2*XLEN-1:0]   w_prod;

`ifdef ALU_MDU_DIV_EN
    logic                w_div_zero;
    logic                w_div_ovf;

    assign w_div_zero = (alu_b_i == '0);
    assign w_div_ovf  = (alu_op_i inside {OP_DIV, OP_REM}) &&
                        (alu_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (alu_b_i == '1);
    // Zero divisor and signed overflow resolve at accept and bypass the engine.
    assign w_go_div   = is_div_op(alu_op_i) && !w_div_zero && !w_div_ovf;
`else
    assign w_go_div   = 1'b0;
`endif

    assign w_go_mul = is_muldiv(alu_op_i) && !is_div_op(alu_op_i);
    assign w_start  = w_accept && (w_go_mul || w_go_div);
    assign w_shamt  = alu_b_i[SHAMT_W-1:0];

    always_comb begin
        w_base = '0;
        case (alu_op_i)
            OP_ADD:      w_base = alu_a_i + alu_b_i;
            OP_SUB:      w_base = alu_a_i - alu_b_i;
            OP_AND:      w_base = alu_a_i & alu_b_i;
            OP_OR:       w_base = alu_a_i | alu_b_i;
            OP_XOR:      w_base = alu_a_i ^ alu_b_i;
            OP_SLL:      w_base = alu_a_i << w_shamt;
            OP_SRL:      w_base = alu_a_i >> w_shamt;
            OP_SRA:      w_base = $signed(alu_a_i) >>> w_shamt;
            OP_SLT:      w_base = {{(XLEN-1){1'b0}}, $signed(alu_a_i) < $signed(alu_b_i)};
            OP_SLTU:     w_base = {{(XLEN-1){1'b0}}, alu_a_i < alu_b_i};
            OP_LUI:      w_base = alu_b_i << IMM_SHIFT;
            OP_AUIPC:    w_base = alu_a_i + (alu_b_i << IMM_SHIFT);
            OP_OUT_ZERO: w_base = '0;
            OP_OUT_ONE:  w_base = XLEN'(1);
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU: w_base = w_div_zero ? '1 : alu_a_i;
            OP_REM, OP_REMU: w_base = w_div_zero ? alu_a_i : '0;
`endif
            default:     w_base = '0;
        endcase
    end

    assign w_neg_a = (alu_op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && alu_a_i[XLEN-1];
    assign w_neg_b = (alu_op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && alu_b_i[XLEN-1];
    assign w_mag_a = w_neg_a ? -alu_a_i : alu_a_i;
    assign w_mag_b = w_neg_b ? -alu_b_i : alu_b_i;

    alu_mdu_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush_i),
        .i_start  (w_start),
`ifdef ALU_MDU_DIV_EN
        .i_is_div (w_go_div),
`endif
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_done   (w_iter_done),
        .o_hi     (w_iter_hi),
        .o_lo     (w_iter_lo)
    );

    // Negating the full {hi,lo} also yields the negated quotient in the low half.
    assign w_prod = (r_neg_a ^ r_neg_b) ? -{w_iter_hi, w_iter_lo} : {w_iter_hi, w_iter_lo};

    always_comb begin
        w_fix = '0;
        case (r_op)
            OP_MUL:                       w_fix = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU:              w_fix = w_prod[XLEN-1:0];
            OP_REM, OP_REMU:              w_fix = r_neg_a ? -w_iter_hi : w_iter_hi;
`endif
            default:                      w_fix = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_MUL, ST_DIV: begin
                if (w_iter_done) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_ready = out_ready_i;
                if (out_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_accept = in_valid_i && w_ready && !flush_i;
        if (w_accept) begin
            w_state_nxt = w_go_mul ? ST_MUL : (w_go_div ? ST_DIV : ST_DONE);
        end
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_ADD;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (flush_i) begin
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= alu_op_i;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            if (!w_go_mul && !w_go_div) begin
                r_result <= w_base;
            end
        end else if (r_state == ST_FIX) begin
            r_result <= w_fix;
        end
    end

    assign in_ready_o   = w_ready;
    assign out_valid_o  = (r_state == ST_DONE);
    assign busy_o       = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
    assign alu_result_o = r_result;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed corner cases plus random ops against an arithmetic reference model.
// Divide expectations follow ALU_MDU_DIV_EN the same way the design build does.
`timescale 1ns/1ps
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    alu_op_t     alu_op    = OP_ADD;
    logic [31:0] alu_a     = '0;
    logic [31:0] alu_b     = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .alu_op_i     (alu_op),
        .alu_a_i      (alu_a),
        .alu_b_i      (alu_b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .alu_result_o (result),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [4:0]  sh;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        r  = '0;
        case (op)
            OP_ADD:      r = a + b;
            OP_SUB:      r = a - b;
            OP_AND:      r = a & b;
            OP_OR:       r = a | b;
            OP_XOR:      r = a ^ b;
            OP_SLL:      r = a << sh;
            OP_SRL:      r = a >> sh;
            OP_SRA:      r = $signed(a) >>> sh;
            OP_SLT:      r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:     r = (a < b) ? 32'd1 : 32'd0;
            OP_LUI:      r = b << 12;
            OP_AUIPC:    r = a + (b << 12);
            OP_OUT_ZERO: r = '0;
            OP_OUT_ONE:  r = 32'd1;
            OP_MUL:      begin p = 64'(sa * sb); r = p[31:0]; end
            OP_MULH:     begin p = 64'(sa * sb); r = p[63:32]; end
            OP_MULHSU:   begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
            OP_MULHU:    begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
`ifdef ALU_MDU_DIV_EN
            OP_DIV:      r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            OP_DIVU:     r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:      r = (b == 0) ? a : 32'(sa % sb);
            OP_REMU:     r = (b == 0) ? a : a % b;
`endif
            default:     r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return XLEN + 2;
`ifdef ALU_MDU_DIV_EN
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
            if (b == 0) return 1;
            if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 2;
        end
`endif
        return 1;
    endfunction

    // Returns #1 after the accept edge with the inputs already scrambled.
    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        alu_a    = a;
        alu_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = OP_SUB;
        alu_a    = $urandom;
        alu_b    = $urandom;
    endtask

    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic run_chk(input string tag, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int          lat;
        int          exp_lat;
        exp_lat = ref_latency(op, a, b);
        issue(op, a, b);
        chk({tag, " busy"}, 64'(busy), 64'(exp_lat > 1));
        wait_result(res, lat);
        chk({tag, " result"}, 64'(res), 64'(ref_result(op, a, b)));
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a multiply, with a nonzero result still held.
        run_chk("add 2+3", OP_ADD, 32'd2, 32'd3);
        issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst mid-mul out_valid", 64'(out_valid), 64'd0);
        chk("rst mid-mul result", 64'(result), 64'd0);
        chk("rst mid-mul in_ready", 64'(in_ready), 64'd1);
        chk("rst mid-mul busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back base ops at one per cycle.
        @(negedge clk);
        in_valid = 1'b1; alu_op = OP_ADD; alu_a = 32'h7FFF_FFFF; alu_b = 32'h1;
        @(negedge clk);
        chk("b2b add valid", 64'(out_valid), 64'd1);
        chk("b2b add", 64'(result), 64'(ref_result(OP_ADD, 32'h7FFF_FFFF, 32'h1)));
        alu_op = OP_SRA; alu_a = 32'h8000_0000; alu_b = 32'd4;
        @(negedge clk);
        chk("b2b sra valid", 64'(out_valid), 64'd1);
        chk("b2b sra", 64'(result), 64'(ref_result(OP_SRA, 32'h8000_0000, 32'd4)));
        alu_op = OP_SLTU; alu_a = 32'h1; alu_b = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("b2b sltu valid", 64'(out_valid), 64'd1);
        chk("b2b sltu", 64'(result), 64'(ref_result(OP_SLTU, 32'h1, 32'hFFFF_FFFF)));
        in_valid = 1'b0;

        run_chk("mulh", OP_MULH, 32'hFFFF_FFFE, 32'h0000_0003);
        run_chk("mulhu", OP_MULHU, 32'hFFFF_FFFE, 32'h0000_0003);
        run_chk("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_chk("remu by 0", OP_REMU, 32'd7, 32'd0);
        run_chk("divu by 0", OP_DIVU, 32'd7, 32'd0);
        run_chk("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_chk("divu 9/3", OP_DIVU, 32'd9, 32'd3);
        run_chk("undef op", alu_op_t'(5'd14), 32'd5, 32'd6);

        // Consumer stall: result and handshake hold steady.
        out_ready = 1'b0;
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
        wait_result(res, lat);
        chk("rem -7/2", 64'(res), 64'(ref_result(OP_REM, 32'hFFFF_FFF9, 32'd2)));
        chk("rem -7/2 latency", 64'(lat), 64'(ref_latency(OP_REM, 32'hFFFF_FFF9, 32'd2)));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall result", 64'(result), 64'(ref_result(OP_REM, 32'hFFFF_FFF9, 32'd2)));
            chk("stall out_valid", 64'(out_valid), 64'd1);
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall release out_valid", 64'(out_valid), 64'd0);

        // Flush during an iterative op.
`ifdef ALU_MDU_DIV_EN
        issue(OP_DIV, 32'd100, 32'd7);
`else
        issue(OP_MUL, 32'd100, 32'd7);
`endif
        seen = out_valid;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (40) begin
            seen = seen | out_valid;
            @(posedge clk);
            #1;
        end
        chk("flush no out_valid", 64'(seen), 64'd0);
        run_chk("post-flush add", OP_ADD, 32'd2, 32'd3);

        for (int i = 0; i < 120; i++) begin
            op = alu_op_t'(5'($urandom_range(0, 31)));
            a  = pick_operand();
            b  = pick_operand();
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_chk("random", op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
